// File: rtl/dac_ad5061_arbiter.sv
// Round-robin arbiter sharing one AD5061 DAC writer between four requesters.
// Latches the granted code, pulses LATCH, tracks SYNC_DAC, and acks or aborts on timeout.
module dac_ad5061_arbiter #(
   parameter int TIMEOUT   = 255,
   parameter int GAP       = 4,
   parameter int LATCH_LEN = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  REQ,
   input  logic [15:0] VAL0,
   input  logic [15:0] VAL1,
   input  logic [15:0] VAL2,
   input  logic [15:0] VAL3,
   input  logic        SYNC_DAC,
   output logic        LATCH,
   output logic [15:0] VALUE,
   output logic [3:0]  ACK,
   output logic        BUSY,
   output logic [1:0]  GRANT_ID,
   output logic        ERR
);

   // state   | meaning
   // IDLE    | waiting for a request while the writer is idle (SYNC_DAC high)
   // PULSE   | LATCH held high for LATCH_LEN cycles
   // WAIT_LO | waiting for the writer to start shifting (SYNC_DAC low)
   // WAIT_HI | waiting for the end of the frame (SYNC_DAC high)
   // ABORT   | writer never responded: flag ERR and release the requester
   // GAP     | enforced idle time before the next grant
   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_WAIT_LO,
      S_WAIT_HI,
      S_ABORT,
      S_GAP
   } state_t;

   localparam int LATCH_CYC = (LATCH_LEN < 1) ? 1 : LATCH_LEN;
   localparam int GAP_CYC   = (GAP < 1) ? 1 : GAP;
   localparam int TO_CYC    = (TIMEOUT < 1) ? 1 : TIMEOUT;
   localparam logic [15:0] TC_LATCH   = 16'(LATCH_CYC - 1);
   localparam logic [15:0] TC_GAP     = 16'(GAP_CYC - 1);
   localparam logic [15:0] TC_TIMEOUT = 16'(TO_CYC - 1);

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt, cnt_inc;
   logic [1:0]  ptr, ptr_nxt;
   logic        latch_q, latch_nxt;
   logic [15:0] value_q, value_nxt;
   logic [1:0]  grant_q, grant_nxt;
   logic [3:0]  ack_q, ack_nxt;
   logic        err_q, err_nxt;

   logic [3:0]  req_rot;
   logic [1:0]  pick_off;
   logic [1:0]  pick_id;
   logic        pick_vld;
   logic [15:0] val_pick;

   // Rotate requests so bit 0 corresponds to ptr; the lowest set bit wins.
   always_comb begin
      req_rot  = 4'({REQ, REQ} >> ptr);
      pick_off = 2'd3;
      if (req_rot[0])      pick_off = 2'd0;
      else if (req_rot[1]) pick_off = 2'd1;
      else if (req_rot[2]) pick_off = 2'd2;
      pick_id  = ptr + pick_off;
      pick_vld = |REQ;
   end

   always_comb begin
      val_pick = VAL0;
      case (pick_id)
         2'd0: val_pick = VAL0;
         2'd1: val_pick = VAL1;
         2'd2: val_pick = VAL2;
         2'd3: val_pick = VAL3;
      endcase
   end

   assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      latch_nxt = latch_q;
      value_nxt = value_q;
      grant_nxt = grant_q;
      ack_nxt   = 4'b0000;
      err_nxt   = err_q;
      case (state)
         S_IDLE: begin
            // A writer still shifting (e.g. after reset or abort) holds off the grant.
            if (pick_vld && SYNC_DAC) begin
               value_nxt = val_pick;
               grant_nxt = pick_id;
               latch_nxt = 1'b1;
               cnt_nxt   = 16'd0;
               state_nxt = S_PULSE;
            end
         end
         S_PULSE: begin
            if (cnt >= TC_LATCH) begin
               latch_nxt = 1'b0;
               cnt_nxt   = 16'd0;
               state_nxt = S_WAIT_LO;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         S_WAIT_LO: begin
            if (!SYNC_DAC) begin
               cnt_nxt   = 16'd0;
               state_nxt = S_WAIT_HI;
            end else if (cnt >= TC_TIMEOUT) begin
               cnt_nxt   = 16'd0;
               state_nxt = S_ABORT;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         S_WAIT_HI: begin
            if (SYNC_DAC) begin
               ack_nxt   = 4'b0001 << grant_q;
               ptr_nxt   = grant_q + 2'd1;
               cnt_nxt   = 16'd0;
               state_nxt = S_GAP;
            end else if (cnt >= TC_TIMEOUT) begin
               cnt_nxt   = 16'd0;
               state_nxt = S_ABORT;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         S_ABORT: begin
            err_nxt   = 1'b1;
            ack_nxt   = 4'b0001 << grant_q;
            ptr_nxt   = grant_q + 2'd1;
            cnt_nxt   = 16'd0;
            state_nxt = S_GAP;
         end
         S_GAP: begin
            if (cnt >= TC_GAP) begin
               cnt_nxt   = 16'd0;
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            cnt_nxt   = 16'd0;
            latch_nxt = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         cnt     <= 16'd0;
         ptr     <= 2'd0;
         latch_q <= 1'b0;
         value_q <= 16'd0;
         grant_q <= 2'd0;
         ack_q   <= 4'b0000;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ptr     <= ptr_nxt;
         latch_q <= latch_nxt;
         value_q <= value_nxt;
         grant_q <= grant_nxt;
         ack_q   <= ack_nxt;
         err_q   <= err_nxt;
      end
   end

   assign LATCH    = latch_q;
   assign VALUE    = value_q;
   assign ACK      = ack_q;
   assign BUSY     = (state != S_IDLE);
   assign GRANT_ID = grant_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_dac_ad5061_arbiter.sv
// Bench for dac_ad5061_arbiter: writer model, directed scenarios and random requesters,
// checked each cycle against a transaction-level reference model.
module tb_dac_ad5061_arbiter;

   localparam int TIMEOUT   = 255;
   localparam int GAP       = 4;
   localparam int LATCH_LEN = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  REQ = 4'b0000;
   logic [15:0] VAL0 = 16'd0, VAL1 = 16'd0, VAL2 = 16'd0, VAL3 = 16'd0;
   logic        SYNC_DAC = 1'b1;
   logic        LATCH;
   logic [15:0] VALUE;
   logic [3:0]  ACK;
   logic        BUSY;
   logic [1:0]  GRANT_ID;
   logic        ERR;

   always #5 CLK = ~CLK;

   dac_ad5061_arbiter #(.TIMEOUT(TIMEOUT), .GAP(GAP), .LATCH_LEN(LATCH_LEN)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ),
      .VAL0(VAL0), .VAL1(VAL1), .VAL2(VAL2), .VAL3(VAL3),
      .SYNC_DAC(SYNC_DAC), .LATCH(LATCH), .VALUE(VALUE), .ACK(ACK),
      .BUSY(BUSY), .GRANT_ID(GRANT_ID), .ERR(ERR)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Writer model: edge detect on LATCH, then SYNC_DAC low for frame_len cycles.
   bit   wr_en     = 1'b1;
   int   frame_len = 40;
   logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
   int   sh_cnt = 0;

   always @(posedge CLK) begin
      d1 <= LATCH;
      d2 <= d1;
      d3 <= d2;
      if (sh_cnt != 0) begin
         sh_cnt <= sh_cnt - 1;
         if (sh_cnt == 1) SYNC_DAC <= 1'b1;
      end else if (wr_en && d2 && !d3) begin
         SYNC_DAC <= 1'b0;
         sh_cnt   <= frame_len;
      end
   end

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   // Reference model state
   int          m_ptr = 0, g = 0, phase = 0, lo_n = 0, latch_n = 0, since_ack = 0;
   bit          xfer = 1'b0, had_ack = 1'b0, m_err = 1'b0;
   logic [15:0] exp_val = 16'd0;
   int          n_grant = 0, n_ack = 0;
   int          gq[$];
   int          vq[$];

   // Inputs as seen by the most recent active edge
   logic [3:0]  req_s = 4'b0000;
   logic [15:0] val_s [4];
   logic        sync_s = 1'b1, busy_s = 1'b0, rst_s = 1'b1;

   initial begin : mon
      bit ack_now, timed, exp_l;
      int eg;
      for (int i = 0; i < 4; i++) val_s[i] = 16'd0;
      forever begin
         @(negedge CLK);
         ack_now = 1'b0;
         timed   = 1'b0;
         if (rst_s) begin
            chk("rst_latch", LATCH, 0);
            chk("rst_ack", ACK, 0);
            chk("rst_busy", BUSY, 0);
            chk("rst_err", ERR, 0);
            chk("rst_gid", GRANT_ID, 0);
            chk("rst_value", VALUE, 0);
            m_ptr = 0; xfer = 1'b0; had_ack = 1'b0; m_err = 1'b0; phase = 0;
         end else begin
            if (xfer) begin
               chk("value_hold", VALUE, exp_val);
               chk("gid_hold", GRANT_ID, g);
               if (phase >= 2) chk("latch_low", LATCH, 0);
               case (phase)
                  1: if (LATCH) latch_n++;
                     else begin
                        chk("latch_len", latch_n, LATCH_LEN);
                        phase = 2; lo_n = 0;
                     end
                  2: if (lo_n == TIMEOUT) begin ack_now = 1'b1; timed = 1'b1; end
                     else if (!sync_s) begin phase = 3; lo_n = 0; end
                     else lo_n++;
                  3: if (lo_n == TIMEOUT) begin ack_now = 1'b1; timed = 1'b1; end
                     else if (sync_s) ack_now = 1'b1;
                     else lo_n++;
                  default: ;
               endcase
            end
            if (ack_now && timed) m_err = 1'b1;
            chk("ack", ACK, ack_now ? (4'b0001 << g) : 4'b0000);
            chk("err", ERR, m_err);
            if (ack_now) begin
               m_ptr = (g + 1) % 4; xfer = 1'b0; phase = 0;
               since_ack = 0; had_ack = 1'b1; n_ack++;
            end else begin
               since_ack++;
            end
            if (!xfer && !ack_now) begin
               exp_l = !busy_s && (req_s != 4'b0000) && sync_s;
               chk("latch_start", LATCH, exp_l);
               if (LATCH) begin
                  eg = rr_pick(req_s, m_ptr);
                  chk("grant_id", GRANT_ID, eg);
                  if (eg < 0) eg = m_ptr;
                  chk("grant_value", VALUE, val_s[eg]);
                  if (had_ack) chk("gap_len", since_ack >= GAP + 1, 1);
                  g = eg; exp_val = val_s[eg]; xfer = 1'b1; phase = 1; latch_n = 1;
                  n_grant++;
                  gq.push_back(eg);
                  vq.push_back(int'(val_s[eg]));
               end
            end
            chk("busy", BUSY, xfer || (had_ack && since_ack < GAP));
         end
         req_s = REQ;
         val_s[0] = VAL0; val_s[1] = VAL1; val_s[2] = VAL2; val_s[3] = VAL3;
         sync_s = SYNC_DAC; busy_s = BUSY; rst_s = RST;
      end
   end

   // Requester behaviour applied once per cycle by the driver
   bit drop_on_ack = 1'b1;
   bit rnd_mode    = 1'b0;

   task automatic set_val(input int i, input logic [15:0] v);
      case (i)
         0: VAL0 = v;
         1: VAL1 = v;
         2: VAL2 = v;
         default: VAL3 = v;
      endcase
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      if (drop_on_ack) REQ = REQ & ~ACK;
      if (rnd_mode) begin
         if (sh_cnt == 0) frame_len = $urandom_range(8, 160);
         for (int i = 0; i < 4; i++) begin
            if (!REQ[i] && !ACK[i] && $urandom_range(0, 7) == 0) begin
               REQ[i] = 1'b1;
               set_val(i, 16'($urandom));
            end else if (REQ[i] && $urandom_range(0, 63) == 0) begin
               set_val(i, 16'($urandom));
            end else if (REQ[i] && $urandom_range(0, 199) == 0) begin
               REQ[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic wait_evt(input bit on_grant, input int target, input int budget, input string tag);
      int c = 0;
      while (((on_grant ? n_grant : n_ack) < target) && c < budget) begin
         tick();
         c++;
      end
      chk({"wait_", tag}, (on_grant ? n_grant : n_ack) >= target, 1);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      tick();
   endtask

   initial begin : drv
      int base, c;
      repeat (3) tick();
      RST = 1'b0;
      tick();

      // Single request
      frame_len = 150;
      VAL0 = 16'hA5C3;
      REQ  = 4'b0001;
      wait_evt(1'b0, n_ack + 1, 600, "t1");
      chk("t1_gid", gq[gq.size() - 1], 0);
      chk("t1_val", vq[vq.size() - 1], 16'hA5C3);
      chk("t1_err", ERR, 0);
      repeat (10) tick();

      // Round-robin with all requests held
      do_reset();
      frame_len = 30;
      VAL0 = 16'd1; VAL1 = 16'd2; VAL2 = 16'd3; VAL3 = 16'd4;
      drop_on_ack = 1'b0;
      base = gq.size();
      REQ = 4'b1111;
      wait_evt(1'b0, n_ack + 5, 2000, "t2");
      REQ = 4'b0000;
      drop_on_ack = 1'b1;
      if (gq.size() >= base + 5)
         for (int k = 0; k < 5; k++) begin
            chk("t2_order", gq[base + k], k % 4);
            chk("t2_value", vq[base + k], (k % 4) + 1);
         end
      repeat (10) tick();

      // Pointer wrap 3 -> 0
      do_reset();
      base = gq.size();
      REQ = 4'b1000;
      wait_evt(1'b0, n_ack + 1, 600, "t3a");
      REQ = 4'b1001;
      wait_evt(1'b0, n_ack + 2, 1200, "t3b");
      if (gq.size() >= base + 3) begin
         chk("t3_first", gq[base], 3);
         chk("t3_wrap", gq[base + 1], 0);
         chk("t3_then", gq[base + 2], 3);
      end
      repeat (10) tick();

      // Timeout with a silent writer
      do_reset();
      wr_en = 1'b0;
      REQ = 4'b0100;
      wait_evt(1'b0, n_ack + 1, 400, "t4");
      chk("t4_gid", gq[gq.size() - 1], 2);
      chk("t4_err", ERR, 1);
      repeat (20) tick();
      chk("t4_err_sticky", ERR, 1);
      wr_en = 1'b1;
      do_reset();
      chk("t4_err_clr", ERR, 0);

      // Code changed mid-frame must not reach VALUE
      frame_len = 150;
      VAL1 = 16'h1234;
      REQ = 4'b0010;
      wait_evt(1'b1, n_grant + 1, 50, "t5g");
      VAL1 = 16'hFFFF;
      wait_evt(1'b0, n_ack + 1, 600, "t5");
      chk("t5_val", vq[vq.size() - 1], 16'h1234);
      repeat (10) tick();

      // Reset while the writer is shifting
      VAL1 = 16'h0BEE;
      REQ = 4'b0010;
      wait_evt(1'b1, n_grant + 1, 50, "t6g");
      c = 0;
      while (SYNC_DAC && c < 50) begin tick(); c++; end
      chk("t6_sync_lo", SYNC_DAC, 0);
      repeat (10) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      base = n_grant;
      wait_evt(1'b0, n_ack + 1, 800, "t6");
      chk("t6_one_grant", n_grant - base, 1);
      chk("t6_gid", gq[gq.size() - 1], 1);
      chk("t6_val", vq[vq.size() - 1], 16'h0BEE);
      repeat (10) tick();

      // Random requesters
      do_reset();
      base = n_ack;
      rnd_mode = 1'b1;
      repeat (8000) tick();
      rnd_mode = 1'b0;
      REQ = 4'b0000;
      chk("rnd_acks", n_ack > base + 10, 1);
      repeat (400) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/dac_ad5061_arbiter.md
Name: dac_ad5061_arbiter

Overview:
- Round-robin arbiter that shares one AD5061 serial DAC writer between 4 requesters.
- Grants one requester at a time and latches that requester's 16-bit code.
- Drives the writer's LATCH/VALUE inputs, then tracks transfer completion by monitoring the writer's SYNC_DAC output.
- Returns a one-cycle ACK to the granted requester; flags a timeout error if the writer never responds.

Parameters:
- TIMEOUT, 255: max cycles to wait for any SYNC_DAC edge before aborting the transfer.
- GAP, 4: minimum idle cycles between end of one transfer and the next LATCH.
- LATCH_LEN, 2: cycles LATCH is held high per transfer (must be >= 1).

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: synchronous, active-high reset.
- REQ, in, 4: request level per requester; held high until the matching ACK bit pulses.
- VAL0, in, 16: code for requester 0.
- VAL1, in, 16: code for requester 1.
- VAL2, in, 16: code for requester 2.
- VAL3, in, 16: code for requester 3.
- SYNC_DAC, in, 1: SYNC_DAC output of the DAC writer (low while shifting).
- LATCH, out, 1: start pulse to the DAC writer.
- VALUE, out, 16: code to the DAC writer; held stable from grant until the transfer ends.
- ACK, out, 4: one-cycle completion pulse, one-hot.
- BUSY, out, 1: high in every state except IDLE.
- GRANT_ID, out, 2: index of the current/last granted requester.
- ERR, out, 1: sticky timeout flag; cleared only by RST.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values (all registered): LATCH=0, VALUE=0, ACK=0, BUSY=0, GRANT_ID=0, ERR=0, state=IDLE, rr pointer=0, counters=0.
- IDLE:
  - If any REQ bit is set, pick the first set bit searching from ptr, ptr+1, ... mod 4. ptr is the index after the last granted requester.
  - Next cycle: VALUE<=VALn, GRANT_ID<=n, LATCH<=1, go to PULSE.
  - Grant latency is 1 cycle from REQ seen in IDLE to LATCH high.
- PULSE: hold LATCH=1 for LATCH_LEN cycles, then LATCH<=0, clear the counter, go to WAIT_LO.
- WAIT_LO: wait for SYNC_DAC==0. The writer has a 2-flop edge detect, so SYNC_DAC falls about 3 cycles after LATCH rises.
  - When seen: go to WAIT_HI, clear the counter.
  - Counter reaches TIMEOUT: go to ABORT.
- WAIT_HI: wait for SYNC_DAC==1 (end of the 24-bit frame, ~150 cycles).
  - When seen: ACK[GRANT_ID]<=1 for exactly one cycle, ptr<=GRANT_ID+1 (wraps 3->0), go to GAP.
  - Counter reaches TIMEOUT: go to ABORT.
- ABORT:
  - ERR<=1 and ACK[GRANT_ID]<=1, so the requester is never stalled forever.
  - Advance ptr as for a normal completion, then go to GAP.
- GAP: count GAP cycles, then go to IDLE. New requests are evaluated only in IDLE.
- VALUE changes only on grant; VALn changes during a transfer have no effect.
- REQ deasserted before ACK: the transfer still completes and is still ACKed; ACK is ignored by the requester.
- Same requester still asserting REQ after ACK:
  - ACK pulses in the cycle the arbiter leaves WAIT_HI, so the requester must drop REQ the cycle after ACK; otherwise it is serviced again.
  - Fairness is guaranteed by the ptr advance.
- All 4 REQ bits high continuously: grant order 0,1,2,3,0,...
- RST mid-transfer:
  - Outputs return to reset values next cycle, and no ACK is issued.
  - The writer may still be shifting. The arbiter, out of reset, waits in IDLE-qualified fashion: it grants only when SYNC_DAC==1.
- SYNC_DAC already low in IDLE (writer busy from a previous abort): grants are held off until SYNC_DAC==1.
- Counters are 16 bits wide; they saturate and never wrap before TIMEOUT is reached.

Test Plan:
1. Single request:
   - Stimulus: REQ=0001, VAL0=16'hA5C3, writer model attached.
   - Required: LATCH high for 2 cycles starting 1 cycle after REQ; VALUE=A5C3 for the whole frame; ACK=0001 for one cycle the cycle after SYNC_DAC rises; ERR=0.
2. Round-robin fairness:
   - Stimulus: REQ=1111 held, VALn=n+1.
   - Required: GRANT_ID sequence 0,1,2,3,0; VALUE sequence 1,2,3,4,1; each ACK bit pulses once per round; at least 4 idle cycles between transfers.
3. Pointer wrap:
   - Stimulus: last grant=3, then REQ=1001.
   - Required: next grant is 0, then 3.
4. Timeout:
   - Stimulus: SYNC_DAC tied 1, REQ=0100.
   - Required: no WAIT_HI; after 255 cycles in WAIT_LO, ACK=0100 for one cycle and ERR=1 until RST.
5. Value stability:
   - Stimulus: change VAL1 from 1234 to FFFF during a requester-1 frame.
   - Required: VALUE stays 1234 until the ACK.
6. Reset mid-frame:
   - Stimulus: assert RST during WAIT_HI while SYNC_DAC=0, with REQ=0010 held.
   - Required: next cycle LATCH=0, ACK=0, BUSY=0; no grant until SYNC_DAC returns to 1; then a normal transfer with GRANT_ID=1.
